// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the integer regfile write port between N_REQ writeback
// sources, with a registered write port and a 32-entry busy scoreboard. Optional
// perf counters (stall_cnt, conflict_cnt) are built when WB_ARB_PERF_EN is defined.
module wb_port_arbiter #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*5-1:0]    req_dest,
  input  logic [N_REQ-1:0]      req_wen,
  input  logic [N_REQ*XLEN-1:0] req_data,
  output logic                  wb_valid,
  output logic [4:0]            wb_dest,
  output logic                  wb_wen,
  output logic [XLEN-1:0]       wb_data,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_dest,
  output logic [31:0]           busy
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           conflict_cnt
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             wb_valid_q, wb_valid_d;
  logic             wb_wen_q, wb_wen_d;
  logic [4:0]       wb_dest_q, wb_dest_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [31:0]      busy_q, busy_d;

  logic             grant_any_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic [PTR_W-1:0] cand_s;
  logic [N_REQ-1:0] grant_oh_s;
  logic [4:0]       sel_dest_s;
  logic             sel_wen_s;
  logic [XLEN-1:0]  sel_data_s;
  logic [31:0]      set_mask_s;
  logic [31:0]      clr_mask_s;

  // Requester index k positions after the pointer, wrapping mod N_REQ.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= N_REQ) begin
      s = s - N_REQ;
    end else begin
      s = s;
    end
    return s[PTR_W-1:0];
  endfunction

  // Round-robin scan: first valid requester at or after rr_ptr wins.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    grant_oh_s  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = rr_idx(rr_ptr_q, k);
      if (!grant_any_s && req_valid[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (reset) begin
      grant_any_s = 1'b0;
    end else begin
      grant_oh_s[grant_idx_s] = grant_any_s;
    end
  end

  assign req_ready  = grant_oh_s;
  assign sel_dest_s = req_dest[int'(grant_idx_s)*5 +: 5];
  assign sel_wen_s  = req_wen[grant_idx_s];
  assign sel_data_s = req_data[int'(grant_idx_s)*XLEN +: XLEN];

  // Pointer advance and writeback register next state.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wb_valid_d = 1'b0;
    wb_wen_d   = 1'b0;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    if (grant_any_s) begin
      if (grant_idx_s == PTR_W'(N_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + PTR_W'(1);
      end
      wb_valid_d = 1'b1;
      wb_wen_d   = sel_wen_s & (sel_dest_s != 5'd0);
      wb_dest_d  = sel_dest_s;
      wb_data_d  = sel_data_s;
    end else begin
      rr_ptr_d   = rr_ptr_q;
    end
  end

  // Scoreboard: a new producer's set overrides the retiring write's clear; x0 never busy.
  always_comb begin
    set_mask_s = (issue_valid && issue_dest != 5'd0) ? (32'd1 << issue_dest) : 32'd0;
    clr_mask_s = (wb_valid_q && wb_wen_q) ? (32'd1 << wb_dest_q) : 32'd0;
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_dest_q  <= 5'd0;
      wb_data_q  <= '0;
      busy_q     <= 32'd0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_wen_q   <= wb_wen_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      busy_q     <= busy_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_wen   = wb_wen_q;
  assign wb_dest  = wb_dest_q;
  assign wb_data  = wb_data_q;
  assign busy     = busy_q;

`ifdef WB_ARB_PERF_EN
  localparam int CNT_W = $clog2(N_REQ + 1);

  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic [31:0]      conflict_cnt_q, conflict_cnt_d;
  logic [CNT_W-1:0] n_valid_s;
  logic [CNT_W-1:0] n_stall_s;

  function automatic logic [CNT_W-1:0] popcnt(input logic [N_REQ-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CNT_W-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {{(33-CNT_W){1'b0}}, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Stalls count every waiting requester; conflicts count cycles with contention.
  always_comb begin
    n_valid_s      = popcnt(req_valid);
    n_stall_s      = popcnt(req_valid & ~grant_oh_s);
    stall_cnt_d    = sat_add(stall_cnt_q, n_stall_s);
    conflict_cnt_d = sat_add(conflict_cnt_q,
                             (n_valid_s >= CNT_W'(2)) ? CNT_W'(1) : CNT_W'(0));
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= 32'd0;
      conflict_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the port and scoreboard.
module tb_wb_port_arbiter;
  localparam int N    = 3;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_wen;
  logic [N*5-1:0]  req_dest;
  logic [N*XLEN-1:0] req_data;
  logic            wb_valid, wb_wen;
  logic [4:0]      wb_dest;
  logic [XLEN-1:0] wb_data;
  logic            issue_valid;
  logic [4:0]      issue_dest;
  logic [31:0]     busy;
`ifdef WB_ARB_PERF_EN
  logic [31:0]     stall_cnt, conflict_cnt;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter #(.N_REQ(N), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
    .req_wen(req_wen), .req_data(req_data),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_wen(wb_wen), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .busy(busy)
`ifdef WB_ARB_PERF_EN
    , .stall_cnt(stall_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // behavioural model state
  int          m_ptr = 0;
  bit          m_wbv = 1'b0, m_wbw = 1'b0;
  bit [4:0]    m_wbd = 5'd0;
  bit [63:0]   m_wbdat = 64'd0;
  bit          m_busy [32];
  longint      m_stall = 0, m_confl = 0;
  int          last_g = -1;

  function automatic int model_grant();
    if (reset) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // One clock: check grant, advance model, check registered outputs after the edge.
  task automatic step();
    int g;
    int nv;
    logic [N-1:0] er;
    #1;
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", {61'd0, req_ready}, {61'd0, er});
    nv = $countones(req_valid);
    if (reset) begin
      m_ptr = 0; m_wbv = 1'b0; m_wbw = 1'b0; m_wbd = 5'd0; m_wbdat = 64'd0;
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      m_stall = 0; m_confl = 0;
    end else begin
      if (m_wbv && m_wbw) m_busy[m_wbd] = 1'b0;
      if (issue_valid && issue_dest != 5'd0) m_busy[issue_dest] = 1'b1;
      if (g >= 0) begin
        m_wbv   = 1'b1;
        m_wbd   = req_dest[g*5 +: 5];
        m_wbdat = req_data[g*XLEN +: XLEN];
        m_wbw   = req_wen[g] && (m_wbd != 5'd0);
        m_ptr   = (g + 1) % N;
        m_stall = m_stall + nv - 1;
      end else begin
        m_wbv   = 1'b0;
        m_wbw   = 1'b0;
        m_stall = m_stall + nv;
      end
      if (nv >= 2) m_confl = m_confl + 1;
      if (m_stall > 64'hFFFF_FFFF) m_stall = 64'hFFFF_FFFF;
      if (m_confl > 64'hFFFF_FFFF) m_confl = 64'hFFFF_FFFF;
    end
    last_g = g;
    @(posedge clk);
    #1;
    chk("wb_valid", {63'd0, wb_valid}, {63'd0, m_wbv});
    chk("wb_wen",   {63'd0, wb_wen},   {63'd0, m_wbw});
    chk("wb_dest",  {59'd0, wb_dest},  {59'd0, m_wbd});
    chk("wb_data",  wb_data, m_wbdat);
    chk("busy",     {32'd0, busy}, {32'd0, busy_vec()});
`ifdef WB_ARB_PERF_EN
    chk("stall_cnt",    {32'd0, stall_cnt},    m_stall);
    chk("conflict_cnt", {32'd0, conflict_cnt}, m_confl);
`endif
  endtask

  bit        pend [N];
  bit [4:0]  p_dest [N];
  bit        p_wen [N];
  bit [63:0] p_data [N];
  int        waitc [N];
  logic [31:0] busy_before;
  int          r;

  initial begin
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    reset = 1'b1; req_valid = '0; req_wen = '0; req_dest = '0; req_data = '0;
    issue_valid = 1'b0; issue_dest = 5'd0;
    step();
    reset = 1'b0;

    // single request from requester 1
    req_valid = 3'b010; req_dest[9:5] = 5'd5; req_wen[1] = 1'b1; req_data[127:64] = 64'hDEAD;
    #1 chk("t1_ready", {61'd0, req_ready}, 64'd2);
    step();
    chk("t1_wbv", {63'd0, wb_valid}, 64'd1);
    chk("t1_dest", {59'd0, wb_dest}, 64'd5);
    chk("t1_wen", {63'd0, wb_wen}, 64'd1);
    chk("t1_data", wb_data, 64'hDEAD);
    req_valid = 3'b111;
    #1 chk("t1_ptr", {61'd0, req_ready}, 64'd4);

    // reset, then all three held valid for six cycles
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_dest = {5'd13, 5'd12, 5'd11}; req_wen = 3'b111;
    req_data = {64'h3333, 64'h2222, 64'h1111};
    for (int k = 0; k < 6; k++) begin
      #1 chk("t2_order", {61'd0, req_ready}, 64'd1 << (k % 3));
      step();
      chk("t2_wbv", {63'd0, wb_valid}, 64'd1);
    end
`ifdef WB_ARB_PERF_EN
    chk("t2_stall", {32'd0, stall_cnt}, 64'd12);
`endif
    req_valid = 3'b000;
    step();

    // write to x0 is consumed without a regfile write
    busy_before = busy;
    req_valid = 3'b001; req_dest[4:0] = 5'd0; req_wen[0] = 1'b1; req_data[63:0] = 64'h1234;
    step();
    req_valid = 3'b000;
    chk("t3_wbv", {63'd0, wb_valid}, 64'd1);
    chk("t3_wen", {63'd0, wb_wen}, 64'd0);
    chk("t3_busy", {32'd0, busy}, {32'd0, busy_before});

    // issue x7, then retire it through requester 0
    issue_valid = 1'b1; issue_dest = 5'd7;
    step();
    issue_valid = 1'b0;
    chk("t4_set", {63'd0, busy[7]}, 64'd1);
    req_valid = 3'b001; req_dest[4:0] = 5'd7; req_wen[0] = 1'b1; req_data[63:0] = 64'h77;
    step();
    req_valid = 3'b000;
    chk("t4_wen", {63'd0, wb_wen}, 64'd1);
    chk("t4_still", {63'd0, busy[7]}, 64'd1);
    step();
    chk("t4_clr", {63'd0, busy[7]}, 64'd0);

    // simultaneous clear and set of x9: set wins
    issue_valid = 1'b1; issue_dest = 5'd9;
    step();
    issue_valid = 1'b0;
    req_valid = 3'b001; req_dest[4:0] = 5'd9; req_wen[0] = 1'b1; req_data[63:0] = 64'h99;
    step();
    req_valid = 3'b000;
    issue_valid = 1'b1; issue_dest = 5'd9;
    step();
    issue_valid = 1'b0;
    chk("t5_setwins", {63'd0, busy[9]}, 64'd1);

    // reset mid-operation with busy = 0xF0 and all requesters valid
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int d = 4; d < 8; d++) begin
      issue_valid = 1'b1; issue_dest = 5'(d);
      step();
    end
    issue_valid = 1'b0;
    chk("t6_busy_pre", {32'd0, busy}, 64'hF0);
    req_valid = 3'b111; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_wbv", {63'd0, wb_valid}, 64'd0);
    chk("t6_busy", {32'd0, busy}, 64'd0);
    #1 chk("t6_first", {61'd0, req_ready}, 64'd1);
    step();
    req_valid = 3'b000;

    // random traffic
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; waitc[i] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (last_g >= 0) pend[last_g] = 1'b0;
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          p_dest[i] = 5'($urandom_range(0, 31));
          p_wen[i]  = $urandom_range(0, 3) != 0;
          p_data[i] = {$urandom, $urandom};
        end
        req_valid[i] = pend[i];
        req_wen[i]   = p_wen[i];
        req_dest[i*5 +: 5]       = p_dest[i];
        req_data[i*XLEN +: XLEN] = p_data[i];
      end
      r = $urandom_range(0, 31);
      issue_dest  = 5'(r);
      issue_valid = ($urandom_range(0, 1) == 1) && !m_busy[r];
      step();
      if (reset) begin
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; waitc[i] = 0; end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req_valid[i]) begin
            if (last_g == i) begin
              chk("starve", {63'd0, waitc[i] <= N - 1}, 64'd1);
              waitc[i] = 0;
            end else begin
              waitc[i]++;
            end
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer register-file write port between N_REQ writeback sources, e.g. ALU, load unit and mul/div.
- Each source presents a reg_writer-shaped request (dest addr, write enable, data) on a valid/ready handshake.
- Grants one request per cycle in round-robin order and registers the winner onto the regfile write port.
- Keeps a 32-entry busy scoreboard that the issue stage uses for RAW hazard checks.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- XLEN, 64, width of write data (word_t).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request i has a writeback pending.
- req_ready  out  N_REQ  request i granted this cycle (combinational, one-hot or zero).
- req_dest  in  N_REQ*5  dest reg addr of request i, slice [5i+4:5i].
- req_wen  in  N_REQ  write enable of request i.
- req_data  in  N_REQ*XLEN  write data of request i, slice [XLEN*i+XLEN-1:XLEN*i].
- wb_valid  out  1  registered writeback valid.
- wb_dest  out  5  registered dest addr.
- wb_wen  out  1  registered regfile write enable.
- wb_data  out  XLEN  registered write data.
- issue_valid  in  1  issue stage dispatches an instruction writing issue_dest.
- issue_dest  in  5  dest reg of the dispatched instruction.
- busy  out  32  scoreboard; bit r = write to xr outstanding.

Behaviour:
- Reset (clk edge with reset=1):
  - wb_valid=0, wb_wen=0, wb_dest=0, wb_data=0.
  - busy=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is 0 whenever reset=1.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, …, wrapping mod N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all others 0.
  - No valid request: req_ready=0.
  - A handshake completes when req_valid[i] & req_ready[i] in the same cycle. The requester must hold its fields stable until then.
- Pointer update:
  - On a grant to i: rr_ptr <= (i+1) mod N_REQ.
  - No grant: rr_ptr is unchanged.
  - Wrap example, N_REQ=3: a grant to 2 sets rr_ptr=0.
- Output register: latency is 1 cycle, so a handshake in cycle t drives the wb_* outputs in cycle t+1.
  - With a grant: wb_valid<=1, wb_dest<=req_dest[i], wb_data<=req_data[i], and wb_wen<=req_wen[i] & (req_dest[i]!=0).
  - With no grant: wb_valid<=0, wb_wen<=0. wb_dest and wb_data hold their previous values.
  - A request with dest x0 is accepted (consumed), but wb_wen=0.
- Scoreboard:
  - Set: issue_valid & issue_dest!=0 sets busy[issue_dest] at the next edge.
  - Clear: wb_valid & wb_wen clears busy[wb_dest] at the next edge. The clear coincides with the regfile write.
  - Same register set and cleared in one cycle: set wins, busy stays 1 (the newer producer is still outstanding).
  - busy[0] is constant 0.
  - Protocol rule: issue stage never issues to a register whose busy bit is 1 (no WAW in flight). The bench asserts this; the RTL does not check it.
- Starvation bound: a continuously valid requester is granted within N_REQ cycles.
- Reset mid-operation: outstanding grants and busy bits are discarded; requesters must re-present after reset.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- Defined: adds outputs stall_cnt (32 bits) and conflict_cnt (32 bits), both reset to 0.
  - stall_cnt increments each cycle with any req_valid[i]=1 & req_ready[i]=0.
  - conflict_cnt increments each cycle with popcount(req_valid)>=2.
  - Both saturate at 0xFFFFFFFF.
- Undefined: the ports and counters do not exist; arbitration and timing are identical.

Test Plan:
- Reset, then a single request: req_valid=3'b010, dest=5, wen=1, data=0xDEAD. Expect req_ready=3'b010; the next cycle wb_valid=1, wb_dest=5, wb_wen=1, wb_data=0xDEAD; then rr_ptr=2.
- All three valid and held for 6 cycles from rr_ptr=0: grant order 0,1,2,0,1,2. wb_valid=1 each cycle after the first; stall_cnt=12 when the feature is enabled.
- Request dest=0, wen=1, data=0x1234: handshake completes; next cycle wb_valid=1, wb_wen=0; busy unchanged.
- issue_valid, dest=7 → busy[7]=1 next cycle. Requester 0 writes x7 → wb_wen=1 one cycle later, busy[7]=0 the cycle after.
- Same cycle: wb writes x9 (busy[9]=1) while issue_valid with dest=9 → busy[9] remains 1.
- Assert reset while req_valid=3'b111 and busy=0x0000_00F0 → next cycle wb_valid=0, busy=0, rr_ptr=0; first grant after reset goes to requester 0.
